stack_mem_sequencer: RTL and testbench

//  Datapath responder to the pipeline state machine. It executes the two-cycle MEM stage of RCALL/RET.
//  - RCALL: pushes the return PC onto the data stack, one byte per MEM cycle.
//  - RET: pops the return PC and presents it for loading in WB.
//  - Owns the stack pointer and drives the data-memory port during MEM.

---
 rtl/stack_mem_sequencer_pkg.sv | 22 ++
 rtl/stack_mem_sequencer_stack_pointer_reg.sv | 21 ++
 rtl/stack_mem_sequencer.sv | 126 ++++++++++++
 tb/tb_stack_mem_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/stack_mem_sequencer_pkg.sv
// Shared stage/group indices and stack operation encoding for the RCALL/RET MEM sequencer.
package stack_mem_sequencer_pkg;
   localparam int STAGE_COUNT = 5;
   localparam int STAGE_IF    = 0;
   localparam int STAGE_ID    = 1;
   localparam int STAGE_EX    = 2;
   localparam int STAGE_MEM   = 3;
   localparam int STAGE_WB    = 4;

   localparam int GROUP_COUNT         = 4;
   localparam int GROUP_ALU           = 0;
   localparam int GROUP_BRANCH        = 1;
   localparam int GROUP_LDST          = 2;
   localparam int GROUP_TWO_CYCLE_MEM = 3;

   localparam int STACK_OP_W = 2;
   typedef enum logic [STACK_OP_W-1:0] {
      STACK_OP_NONE = 2'd0,
      STACK_OP_PUSH = 2'd1,
      STACK_OP_POP  = 2'd2
   } stack_op_e;
endpackage

// File: rtl/stack_mem_sequencer_stack_pointer_reg.sv
// Stack pointer register: +2 after a pop, -1 per pushed byte, otherwise holds; resets to SP_INIT.
module stack_pointer_reg #(
   parameter int                ADDR_W  = 8,
   parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_inc2,
   input  logic              i_dec1,
   output logic [ADDR_W-1:0] o_sp
);
   logic [ADDR_W-1:0] r_sp;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       r_sp <= SP_INIT;
      else if (i_inc2) r_sp <= r_sp + ADDR_W'(2);
      else if (i_dec1) r_sp <= r_sp - ADDR_W'(1);
   end

   assign o_sp = r_sp;
endmodule

// File: rtl/stack_mem_sequencer.sv
// Two-cycle MEM sequencer for RCALL (push return PC) and RET (pop return PC, load in WB).
// Optional STACK_OVF_CHECK_EN suppresses over/underflowing operations and raises sticky stack_err.
module stack_mem_sequencer
   import stack_mem_sequencer_pkg::*;
#(
   parameter int                ADDR_W  = 8,
   parameter int                PC_W    = 10,
   parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [STAGE_COUNT-1:0] pipeline_stage,
   input  logic                   cycle_count,
   input  logic [GROUP_COUNT-1:0] opcode_group,
   input  logic                   op_call,
   input  logic                   op_ret,
   input  logic [PC_W-1:0]        pc_ret,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [7:0]             mem_wdata,
   output logic                   mem_we,
   output logic                   mem_re,
   input  logic [7:0]             mem_rdata,
   output logic [ADDR_W-1:0]      sp,
   output logic                   pc_load,
   output logic [PC_W-1:0]        pc_out,
   output logic                   stack_err
);
   stack_op_e   r_op;
   stack_op_e   w_op;
   stack_op_e   w_op_nxt;
   logic [PC_W-1:0] r_pc;
   logic [7:0]  r_hi;
   logic [PC_W-1:0] r_pc_out;
   logic [15:0] w_pc16;
   logic        w_grp, w_id, w_ex, w_mem, w_wb;
   logic        w_inc2, w_dec1, w_ovf;
   logic        w_unused;

   assign w_grp  = opcode_group[GROUP_TWO_CYCLE_MEM];
   assign w_id   = pipeline_stage[STAGE_ID];
   assign w_ex   = pipeline_stage[STAGE_EX];
   assign w_mem  = pipeline_stage[STAGE_MEM];
   assign w_wb   = pipeline_stage[STAGE_WB];
   assign w_op   = w_grp ? r_op : STACK_OP_NONE;
   assign w_pc16 = 16'(r_pc);
   assign w_unused = &{1'b0, pipeline_stage[STAGE_IF], opcode_group};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_op <= STACK_OP_NONE;
      else        r_op <= w_op_nxt;
   end

   always_comb begin
      w_op_nxt  = r_op;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      w_inc2    = 1'b0;
      w_dec1    = 1'b0;
      pc_load   = 1'b0;
      w_ovf     = 1'b0;
`ifdef STACK_OVF_CHECK_EN
      w_ovf = w_mem && !cycle_count &&
              ((w_op == STACK_OP_PUSH && sp < ADDR_W'(2)) ||
               (w_op == STACK_OP_POP  && sp > SP_INIT - ADDR_W'(2)));
`endif
      if (!w_grp)     w_op_nxt = STACK_OP_NONE;
      else if (w_id)  w_op_nxt = op_call ? STACK_OP_PUSH :
                                 op_ret  ? STACK_OP_POP  : STACK_OP_NONE;
      else if (w_wb)  w_op_nxt = STACK_OP_NONE;
      else if (w_ovf) w_op_nxt = STACK_OP_NONE;

      // A faulting op is dropped at cc0, so cc1 and WB see NONE.
      if (w_mem && !w_ovf) begin
         case (w_op)
            STACK_OP_PUSH: begin
               mem_addr  = sp;
               mem_wdata = cycle_count ? w_pc16[15:8] : w_pc16[7:0];
               mem_we    = 1'b1;
               w_dec1    = 1'b1;
            end
            STACK_OP_POP: begin
               mem_addr = cycle_count ? sp + ADDR_W'(2) : sp + ADDR_W'(1);
               mem_re   = 1'b1;
               w_inc2   = cycle_count;
            end
            default: ;
         endcase
      end
      if (w_wb && w_op == STACK_OP_POP) pc_load = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc     <= '0;
         r_hi     <= '0;
         r_pc_out <= '0;
      end else begin
         if (w_ex && w_op == STACK_OP_PUSH) r_pc <= pc_ret;
         if (mem_re && !cycle_count)        r_hi <= mem_rdata;
         if (mem_re && cycle_count)         r_pc_out <= PC_W'({r_hi, mem_rdata});
      end
   end

   assign pc_out = r_pc_out;

`ifdef STACK_OVF_CHECK_EN
   logic r_err;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      r_err <= 1'b0;
      else if (w_ovf) r_err <= 1'b1;
   end
   assign stack_err = r_err;
`else
   assign stack_err = 1'b0;
`endif

   stack_pointer_reg #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT)) u_sp (
      .i_clk  (clk),
      .i_rst  (reset),
      .i_inc2 (w_inc2),
      .i_dec1 (w_dec1),
      .o_sp   (sp)
   );
endmodule

// File: tb/tb_stack_mem_sequencer.sv
// Randomized bench for stack_mem_sequencer against a byte-array/integer-SP stack model.
module tb_stack_mem_sequencer;
   import stack_mem_sequencer_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [STAGE_COUNT-1:0] pipeline_stage;
   logic                   cycle_count;
   logic [GROUP_COUNT-1:0] opcode_group;
   logic                   op_call, op_ret;
   logic [9:0]             pc_ret;
   logic [7:0]             mem_addr, mem_wdata, mem_rdata, sp;
   logic                   mem_we, mem_re, pc_load, stack_err;
   logic [9:0]             pc_out;

   logic [7:0] tb_mem [256];
   logic [7:0] m_mem  [256];
   int         m_sp;
   logic [9:0] m_pcout;
   logic       m_err;
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;
   assign mem_rdata = tb_mem[mem_addr];

   stack_mem_sequencer dut (
      .clk(clk), .reset(reset), .pipeline_stage(pipeline_stage), .cycle_count(cycle_count),
      .opcode_group(opcode_group), .op_call(op_call), .op_ret(op_ret), .pc_ret(pc_ret),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .sp(sp), .pc_load(pc_load), .pc_out(pc_out), .stack_err(stack_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_stage(input int s, input bit cc);
      pipeline_stage    = '0;
      pipeline_stage[s] = 1'b1;
      cycle_count       = cc;
   endtask

   task automatic chk_idle(input string tag);
      check_eq({tag, ".we"},   32'(mem_we),   32'd0);
      check_eq({tag, ".re"},   32'(mem_re),   32'd0);
      check_eq({tag, ".addr"}, 32'(mem_addr), 32'd0);
   endtask

   task automatic model_reset();
      m_sp = 255; m_pcout = '0; m_err = 1'b0;
   endtask

   // One full instruction IF..WB; abort=1 asserts reset during MEM cc1.
   task automatic run_instr(input bit call, input bit ret, input bit grp,
                            input logic [9:0] pc, input bit abort);
      int         op;
      logic [7:0] a, hi, lo;
      op = !grp ? 0 : call ? 1 : ret ? 2 : 0;
      hi = '0;
      opcode_group = grp ? GROUP_COUNT'(1 << GROUP_TWO_CYCLE_MEM) : GROUP_COUNT'(1 << GROUP_ALU);

      set_stage(STAGE_IF, 0); op_call = 0; op_ret = 0; pc_ret = 10'($urandom);
      @(negedge clk); chk_idle("if"); check_eq("if.pc_load", 32'(pc_load), 0); tick();

      set_stage(STAGE_ID, 0); op_call = call; op_ret = ret;
      @(negedge clk); chk_idle("id"); tick();

      set_stage(STAGE_EX, 0); op_call = 1'($urandom); op_ret = 1'($urandom); pc_ret = pc;
      @(negedge clk); chk_idle("ex"); tick();
      pc_ret = 10'($urandom);

      set_stage(STAGE_MEM, 0);
`ifdef STACK_OVF_CHECK_EN
      if ((op == 1 && m_sp < 2) || (op == 2 && m_sp > 253)) begin
         m_err = 1'b1; op = 0;
      end
`endif
      @(negedge clk);
      if (op == 1) begin
         check_eq("push0.we", 32'(mem_we), 1); check_eq("push0.re", 32'(mem_re), 0);
         check_eq("push0.addr", 32'(mem_addr), 32'(m_sp));
         check_eq("push0.wdata", 32'(mem_wdata), 32'(pc[7:0]));
         m_mem[m_sp] = pc[7:0];
         if (mem_we) tb_mem[mem_addr] = mem_wdata;
      end else if (op == 2) begin
         a = 8'(m_sp + 1);
         check_eq("pop0.re", 32'(mem_re), 1); check_eq("pop0.we", 32'(mem_we), 0);
         check_eq("pop0.addr", 32'(mem_addr), 32'(a));
         hi = m_mem[a];
      end else chk_idle("mem0");
      tick();
      if (op == 1) m_sp = (m_sp + 255) % 256;

      set_stage(STAGE_MEM, 1);
      if (abort) begin
         #1 reset = 1'b1;
         #1;
         model_reset(); op = 0;
         check_eq("rst.sp", 32'(sp), 32'hFF); chk_idle("rst");
         check_eq("rst.pc_out", 32'(pc_out), 0); check_eq("rst.err", 32'(stack_err), 0);
         #1 reset = 1'b0;
      end
      @(negedge clk);
      check_eq("mem1.err", 32'(stack_err), 32'(m_err));
      if (op == 1) begin
         check_eq("push1.we", 32'(mem_we), 1); check_eq("push1.re", 32'(mem_re), 0);
         check_eq("push1.addr", 32'(mem_addr), 32'(m_sp));
         check_eq("push1.wdata", 32'(mem_wdata), 32'(pc >> 8));
         m_mem[m_sp] = 8'(pc >> 8);
         if (mem_we) tb_mem[mem_addr] = mem_wdata;
      end else if (op == 2) begin
         a = 8'(m_sp + 2);
         check_eq("pop1.re", 32'(mem_re), 1); check_eq("pop1.we", 32'(mem_we), 0);
         check_eq("pop1.addr", 32'(mem_addr), 32'(a));
         lo = m_mem[a];
         m_pcout = 10'({hi, lo});
      end else chk_idle("mem1");
      tick();
      if (op == 1) m_sp = (m_sp + 255) % 256;
      if (op == 2) m_sp = (m_sp + 2) % 256;

      set_stage(STAGE_WB, 0);
      @(negedge clk);
      chk_idle("wb");
      check_eq("wb.pc_load", 32'(pc_load), (op == 2) ? 32'd1 : 32'd0);
      check_eq("wb.pc_out", 32'(pc_out), 32'(m_pcout));
      check_eq("wb.sp", 32'(sp), 32'(m_sp));
      check_eq("wb.err", 32'(stack_err), 32'(m_err));
      tick();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         tb_mem[i] = 8'($urandom);
         m_mem[i]  = tb_mem[i];
      end
      reset = 1'b1; op_call = 1'b1; op_ret = 1'b0; pc_ret = 10'h3FF;
      opcode_group = GROUP_COUNT'(1 << GROUP_TWO_CYCLE_MEM);
      set_stage(STAGE_MEM, 0);
      model_reset();
      #12;
      check_eq("reset.sp", 32'(sp), 32'hFF);
      chk_idle("reset");
      check_eq("reset.pc_load", 32'(pc_load), 0);
      check_eq("reset.pc_out", 32'(pc_out), 0);
      check_eq("reset.err", 32'(stack_err), 0);
      @(posedge clk); #1 reset = 1'b0;

      run_instr(0, 0, 0, 10'h155, 0);                 // ADD-like instruction
      run_instr(1, 0, 1, 10'h123, 0);                 // RCALL
      check_eq("rcall.sp", 32'(sp), 32'hFD);
      check_eq("rcall.lo", 32'(tb_mem[8'hFF]), 32'h23);
      check_eq("rcall.hi", 32'(tb_mem[8'hFE]), 32'h01);
      run_instr(0, 1, 1, 10'h000, 0);                 // RET
      check_eq("ret.pc_out", 32'(pc_out), 32'h123);
      check_eq("ret.sp", 32'(sp), 32'hFF);
      run_instr(1, 0, 1, 10'h2A5, 1);                 // reset mid-push
      run_instr(0, 1, 1, 10'h000, 0);                 // pop from reset SP
      run_instr(1, 1, 1, 10'h3C7, 0);                 // call wins
      run_instr(1, 0, 0, 10'h0AA, 0);                 // gated by group
      run_instr(0, 1, 0, 10'h0AA, 0);

      reset = 1'b1; #2 reset = 1'b0; model_reset();
      run_instr(0, 1, 1, 10'h000, 0);                 // RET at SP_INIT
`ifdef STACK_OVF_CHECK_EN
      check_eq("ovf.err", 32'(stack_err), 1);
      check_eq("ovf.sp", 32'(sp), 32'hFF);
`else
      check_eq("wrap.sp", 32'(sp), 32'h01);
`endif

      for (int n = 0; n < 200; n++)
         run_instr(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 10'($urandom), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
